conv_seq_ctrl: RTL
==================

// Module: conv_seq_ctrl
// PURPOSE
//  Parametrised successor of the fixed 3-row convolution control FSM. Sequences a KxK MAC
//  datapath over KROWS row phases for num_patches patches, with an optional bias stage,
//  start/busy/done handshake, output valid/ready backpressure and an internal patch counter.
//  Sits between the top-level scheduler and the conv datapath (address gen, MAC mux, accumulator).
// PARAMETERS
//  KROWS     3   kernel row phases per patch, 1..15; mux_sel steps 1..KROWS
//  SEL_W     2   mux_sel width; must satisfy 2**SEL_W > KROWS
//  NPATCH_W  10  width of num_patches / patch_idx
//  BIAS_EN   1   1: insert BIAS state after ACC; 0: skip it
// PORTS
//  clk             in   1         rising-edge clock
//  rst             in   1         synchronous active-high reset
//  start           in   1         begin a run; sampled only in IDLE
//  num_patches     in   NPATCH_W  patches in this run; latched when start accepted
//  out_ready       in   1         downstream accepts accumulator result
//  addr            out  1         address-generate strobe (ADDR)
//  flush_acc       out  1         clear accumulator (ADDR)
//  load            out  1         load operand registers (LOAD)
//  mux_sel         out  SEL_W     MAC row select; 0 outside MAC
//  acc_enable      out  1         accumulate strobe (ACC)
//  bias_enable     out  1         bias add strobe (BIAS)
//  out_valid       out  1         result valid (OUT)
//  counter_enable  out  1         advance external address counters (UPDATE)
//  patch_idx       out  NPATCH_W  index of patch being processed
//  busy            out  1         high in every state except IDLE
//  done            out  1         one-cycle pulse at end of run (DONE)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset (any cycle, incl. mid-run): state=IDLE,
//    row counter=0, patch_idx=0, latched count=0; every output 0 in the cycle after rst.
//  - Strobe outputs are Moore decodes of the state register; patch_idx/row counter registered.
//  - States: IDLE, ADDR, LOAD, MAC, SUM, ACC, BIAS, OUT, UPDATE, DONE.
//  - IDLE: start=1 -> latch num_patches, patch_idx<=0; if num_patches==0 -> DONE, else ADDR.
//    start outside IDLE ignored; num_patches changes after acceptance ignored.
//  - ADDR(addr=1,flush_acc=1) -> LOAD(load=1) -> MAC with row=1.
//  - MAC: mux_sel=row; row==KROWS -> SUM, row reset to 0; else row<=row+1, stay.
//  - SUM: mux_sel=0 -> ACC(acc_enable=1) -> BIAS(bias_enable=1) if BIAS_EN else OUT.
//  - OUT: out_valid=1, held with stable patch_idx until out_ready=1; handshake completes in
//    cycle where out_valid&out_ready -> UPDATE. out_ready outside OUT has no effect.
//  - UPDATE: counter_enable=1; if patch_idx==count-1 -> DONE (patch_idx held), else
//    patch_idx<=patch_idx+1 -> ADDR. patch_idx never wraps within a run.
//  - DONE: done=1 for exactly one cycle -> IDLE. start during DONE ignored; back-to-back run
//    accepted earliest in the IDLE cycle following DONE.
//  - Latency per patch with out_ready=1: KROWS+6+BIAS_EN cycles (defaults: 10).
//    Run of N>0 patches: start accepted at cycle 0, done at cycle 1+N*(KROWS+6+BIAS_EN).
//  - Exactly one of addr/load/acc_enable/bias_enable/out_valid/counter_enable/done high per
//    cycle, or none (IDLE, MAC, SUM); flush_acc only with addr.
// TESTING
//  1 Defaults, num_patches=1, out_ready=1, start pulse at t0 -> sequence ADDR,LOAD,
//    mux_sel 1,2,3, SUM(0),ACC,BIAS,OUT,UPDATE; done at t0+11; busy high t1..t11.
//  2 num_patches=4, out_ready tied 1 -> patch_idx 0,1,2,3; 4 counter_enable pulses; done at t0+41.
//  3 out_ready low 5 cycles in OUT of patch 0 -> out_valid held 6 cycles, patch_idx=0 stable,
//    no counter_enable until handshake; total run length +5.
//  4 KROWS=5,SEL_W=3,BIAS_EN=0 -> mux_sel 1..5, bias_enable never high, 11 cycles/patch.
//  5 num_patches=0 with start -> DONE next cycle, done one pulse, no other strobe asserted.
//  6 rst asserted in MAC of patch 2 -> next cycle IDLE, all outputs 0, patch_idx 0; start
//    while busy ignored; new start after reset begins fresh run at patch 0.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Row-phased KxK convolution sequencer: ADDR, LOAD, KROWS MAC phases, SUM, ACC, optional BIAS, OUT, UPDATE per patch.
// Outputs are registered. OUT holds until out_ready. One patch takes KROWS+6+BIAS_EN cycles when out_ready stays high.
module conv_seq_ctrl #(
    parameter int KROWS    = 3,
    parameter int SEL_W    = 2,
    parameter int NPATCH_W = 10,
    parameter int BIAS_EN  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NPATCH_W-1:0] num_patches,
    input  logic                out_ready,
    output logic                addr,
    output logic                flush_acc,
    output logic                load,
    output logic [SEL_W-1:0]    mux_sel,
    output logic                acc_enable,
    output logic                bias_enable,
    output logic                out_valid,
    output logic                counter_enable,
    output logic [NPATCH_W-1:0] patch_idx,
    output logic                busy,
    output logic                done
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_LOAD, S_MAC, S_SUM, S_ACC, S_BIAS, S_OUT, S_UPDATE, S_DONE
    } state_t;

    typedef struct packed {
        logic             addr;
        logic             flush_acc;
        logic             load;
        logic             acc_enable;
        logic             bias_enable;
        logic             out_valid;
        logic             counter_enable;
        logic             busy;
        logic             done;
        logic [SEL_W-1:0] mux_sel;
    } ctrl_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    row_q, row_d;
    logic [NPATCH_W-1:0] patch_q, patch_d;
    logic [NPATCH_W-1:0] count_q, count_d;
    ctrl_t               ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        patch_d = patch_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = num_patches;
                    patch_d = '0;
                    state_d = (num_patches == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_MAC;
                row_d   = SEL_W'(1);
            end
            S_MAC: begin
                if (row_q == SEL_W'(KROWS)) begin
                    state_d = S_SUM;
                    row_d   = '0;
                end else begin
                    row_d = row_q + SEL_W'(1);
                end
            end
            S_SUM: state_d = S_ACC;
            S_ACC: state_d = (BIAS_EN != 0) ? S_BIAS : S_OUT;
            S_BIAS: state_d = S_OUT;
            S_OUT: begin
                if (out_ready) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                // Last patch keeps its index so DONE still reports it.
                if (patch_q == count_q - NPATCH_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    patch_d = patch_q + NPATCH_W'(1);
                    state_d = S_ADDR;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the registered copy tracks state_q exactly.
    always_comb begin
        ctrl_d      = '0;
        ctrl_d.busy = (state_d != S_IDLE);
        case (state_d)
            S_ADDR: begin
                ctrl_d.addr      = 1'b1;
                ctrl_d.flush_acc = 1'b1;
            end
            S_LOAD:   ctrl_d.load           = 1'b1;
            S_MAC:    ctrl_d.mux_sel        = row_d;
            S_ACC:    ctrl_d.acc_enable     = 1'b1;
            S_BIAS:   ctrl_d.bias_enable    = 1'b1;
            S_OUT:    ctrl_d.out_valid      = 1'b1;
            S_UPDATE: ctrl_d.counter_enable = 1'b1;
            S_DONE:   ctrl_d.done           = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            patch_q <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            patch_q <= patch_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign addr           = ctrl_q.addr;
    assign flush_acc      = ctrl_q.flush_acc;
    assign load           = ctrl_q.load;
    assign mux_sel        = ctrl_q.mux_sel;
    assign acc_enable     = ctrl_q.acc_enable;
    assign bias_enable    = ctrl_q.bias_enable;
    assign out_valid      = ctrl_q.out_valid;
    assign counter_enable = ctrl_q.counter_enable;
    assign busy           = ctrl_q.busy;
    assign done           = ctrl_q.done;
    assign patch_idx      = patch_q;

endmodule
